// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serial bitstream loader with shadow/commit, abort and readback
module cfg_chain_loader #(
   parameter int NUM_BLOCKS = 2,
   parameter int BLOCK_BITS = 96
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              prgm_b,
   input  logic                                              rb_req,
   input  logic                                              bit_in,
   input  logic                                              bit_valid,
   output logic                                              bit_ready,
   output logic [NUM_BLOCKS*BLOCK_BITS-1:0]                  cfg_q,
   output logic                                              cfg_update,
   output logic                                              rb_bit,
   output logic                                              rb_valid,
   output logic                                              busy,
   output logic                                              done,
   output logic                                              err,
   output logic [((NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1)-1:0] blk_idx
);

   localparam int TOTAL = NUM_BLOCKS * BLOCK_BITS;
   localparam int BW    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int CW    = $clog2(BLOCK_BITS);
   localparam int RW    = $clog2(TOTAL);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SHIFT    = 3'd1,
      S_COMMIT   = 3'd2,
      S_DONE     = 3'd3,
      S_READBACK = 3'd4
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [BLOCK_BITS-1:0] shadow [NUM_BLOCKS];
   logic [CW-1:0]         bit_cnt;
   logic [RW-1:0]         rb_cnt;
   logic                  last_bit;
   logic                  last_block;
   logic                  last_rb;

   assign last_bit   = (bit_cnt == CW'(BLOCK_BITS - 1));
   assign last_block = (blk_idx == BW'(NUM_BLOCKS - 1));
   assign last_rb    = (rb_cnt == RW'(TOTAL - 1));

   // State register; reset drops any load or readback in progress immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state selection plus the outputs decoded purely from the state.
   always_comb begin
      state_next = state;
      bit_ready  = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (!prgm_b)     state_next = S_SHIFT;
            else if (rb_req) state_next = S_READBACK;
         end
         S_SHIFT: begin
            bit_ready = 1'b1;
            if (prgm_b)                                     state_next = S_IDLE;
            else if (bit_valid && last_bit && last_block)   state_next = S_COMMIT;
         end
         S_COMMIT:   state_next = S_DONE;
         S_DONE:     if (prgm_b) state_next = S_IDLE;
         S_READBACK: if (last_rb) state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   // Datapath: shadow fill, counters, one-shot commit, sticky flags and readback serialiser.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BLOCKS; i++) shadow[i] <= '0;
         cfg_q      <= '0;
         bit_cnt    <= '0;
         blk_idx    <= '0;
         rb_cnt     <= '0;
         cfg_update <= 1'b0;
         rb_bit     <= 1'b0;
         rb_valid   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         cfg_update <= 1'b0;
         rb_valid   <= 1'b0;
         rb_bit     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!prgm_b) begin
                  done    <= 1'b0;
                  err     <= 1'b0;
                  bit_cnt <= '0;
                  blk_idx <= '0;
               end else if (rb_req) begin
                  rb_cnt <= '0;
               end
            end
            S_SHIFT: begin
               // An abort wins over a bit offered in the same cycle.
               if (prgm_b) begin
                  err <= 1'b1;
               end else if (bit_valid) begin
                  shadow[blk_idx] <= {bit_in, shadow[blk_idx][BLOCK_BITS-1:1]};
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (!last_block) blk_idx <= blk_idx + BW'(1);
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
            end
            S_COMMIT: begin
               for (int i = 0; i < NUM_BLOCKS; i++)
                  cfg_q[i*BLOCK_BITS +: BLOCK_BITS] <= shadow[i];
               cfg_update <= 1'b1;
               done       <= 1'b1;
            end
            S_READBACK: begin
               rb_valid <= 1'b1;
               rb_bit   <= cfg_q[rb_cnt];
               rb_cnt   <= last_rb ? '0 : rb_cnt + RW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Parametrised configuration loader for a row of connection blocks. It accepts a serial, LSB-first bitstream under a valid/ready handshake and fills NUM_BLOCKS shadow registers of BLOCK_BITS each, in block order. Once the frame is complete, it commits all shadows to the active configuration in one cycle. It also supports abort detection and serial readback of the active configuration, and it replaces per-block daisy-chained token enables with a single controller that drives the flat configuration bus into the routing fabric.

## Interface
- NUM_BLOCKS, 2, number of connection blocks; must be ≥1.
- BLOCK_BITS, 96, configuration bits per block; must be ≥2.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- prgm_b  in  1  active-low program request; low starts and holds a load.
- rb_req  in  1  readback request, sampled in IDLE only.
- bit_in  in  1  serial configuration bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  loader accepts a bit this cycle.
- cfg_q  out  NUM_BLOCKS*BLOCK_BITS  active configuration; block i occupies [i*BLOCK_BITS +: BLOCK_BITS].
- cfg_update  out  1  one-cycle pulse on the cycle cfg_q takes new contents.
- rb_bit  out  1  readback data bit.
- rb_valid  out  1  rb_bit is valid.
- busy  out  1  state is not IDLE.
- done  out  1  sticky flag: the last load committed.
- err  out  1  sticky flag: the last load was aborted.
- blk_idx  out  max(1,clog2(NUM_BLOCKS))  block currently being loaded.

## Operation
- States and transitions:
  - IDLE
    - prgm_b==0 → SHIFT. Clear done and err; bit_cnt=0; blk_idx=0.
    - else rb_req==1 → READBACK. rb_cnt=0.
    - If prgm_b low and rb_req high together, program wins.
  - SHIFT
    - bit_ready=1.
    - On bit_valid && bit_ready, shift bit_in into shadow[blk_idx] from the MSB side, so after BLOCK_BITS bits the first-received bit sits at bit 0.
    - bit_cnt increments; at BLOCK_BITS-1 it wraps to 0 and blk_idx increments.
    - Accepting bit BLOCK_BITS-1 of block NUM_BLOCKS-1 → COMMIT.
  - Abort
    - prgm_b==1 sampled in SHIFT → IDLE with err=1.
    - Shadows are discarded; cfg_q is unchanged.
    - Abort takes priority over a bit accepted in the same cycle.
  - COMMIT
    - cfg_q <= all shadows simultaneously; cfg_update=1; done=1.
    - Next state: DONE.
  - DONE
    - Hold while prgm_b==0.
    - prgm_b==1 → IDLE; done stays 1.
  - READBACK
    - rb_valid=1 each cycle for NUM_BLOCKS*BLOCK_BITS cycles.
    - rb_bit = cfg_q[rb_cnt], starting at block 0 bit 0.
    - After the last bit → IDLE. prgm_b is ignored until readback completes.
- bit_valid outside SHIFT is ignored, and bit_ready=0 there.
- Counter widths: bit_cnt is clog2(BLOCK_BITS); rb_cnt is clog2(NUM_BLOCKS*BLOCK_BITS). Both wrap only at the defined terminal counts.

## Timing
- All outputs are registered, or decoded from the registered state only.
- Reset values: state IDLE; shadows, cfg_q, counters, blk_idx 0; bit_ready, cfg_update, rb_bit, rb_valid, busy, done, err 0.
- Reset mid-load or mid-readback: immediate return to IDLE, and cfg_q clears to 0.
- Start latency:
  - prgm_b low sampled at edge n → bit_ready=1 after edge n.
  - First bit can be accepted at edge n+1.
- Load throughput: one bit per cycle. With continuous valid, the load takes NUM_BLOCKS*BLOCK_BITS accepting edges.
- Commit latency:
  - Last bit accepted at edge m → COMMIT during cycle m..m+1.
  - cfg_q, cfg_update and done are registered at edge m+1.
  - cfg_update deasserts at edge m+2.
- Backpressure: the loader never stalls while in SHIFT; bubbles come only from bit_valid=0.
- Readback:
  - rb_req sampled at edge r → first rb_valid cycle follows edge r+1.
  - Exactly NUM_BLOCKS*BLOCK_BITS contiguous valid cycles.

## Test plan
All scenarios use defaults (2×96).

- Basic load:
  - Stimulus: reset pulse; prgm_b low; stream 192 bits, LSB-first per block, with bits 0 and 95 of each block =1, others 0, bit_valid continuous.
  - Response: cfg_q bits 0, 95, 96, 191 =1 and all others 0; cfg_update one cycle; done=1; err=0; blk_idx reads 1 during the second block.
- Bubbles:
  - Stimulus: same stream with bit_valid toggling every other cycle.
  - Response: identical cfg_q; done exactly one edge after the 192nd accepted bit; no bits dropped or duplicated.
- Abort:
  - Stimulus: load 0xFF..-pattern fully, then start a new load of all-zero bits and raise prgm_b after 100 bits.
  - Response: err=1; done=0; cfg_q still holds the previous all-ones; busy=0.
- Reset mid-load:
  - Stimulus: assert reset after 50 bits.
  - Response: all outputs 0 immediately (asynchronous); a subsequent full load completes normally.
- Readback:
  - Stimulus: after the basic load, pulse rb_req with prgm_b high.
  - Response: 192 rb_valid cycles; rb_bit=1 only on cycles 0, 95, 96, 191.
- Simultaneous requests:
  - Stimulus: prgm_b low and rb_req high on the same edge in IDLE.
  - Response: SHIFT entered; rb_valid stays 0; bit_ready=1 next cycle.
